mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Sequential signed 32x32 multiplier for the MIPS datapath; the arithmetic counterpart of the iterative divider.
- Produces a 64-bit product into the `hi` (upper word) and `lo` (lower word) registers, as consumed by MULT/MFHI/MFLO.
- Radix-2 Booth algorithm, one iteration per clock, controlled by a start/done handshake from the control unit.

Parameters:
- `WIDTH`, 32, operand width; product is 2*`WIDTH`.
- `CNT_W`, 6, iteration counter width; must hold the value `WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a multiply; sampled only in IDLE
- `A`  in  `WIDTH`  signed multiplicand; sampled on an accepted start
- `B`  in  `WIDTH`  signed multiplier; sampled on an accepted start
- `hi`  out  `WIDTH`  upper word of product (registered)
- `lo`  out  `WIDTH`  lower word of product (registered)
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse when `hi`/`lo` are updated

Behaviour:
- Reset: one clock and reset, as already decided. Reset is synchronous and active-high, sampled on the rising edge of `clk`. On reset:
  - state goes to IDLE;
  - `hi`, `lo`, `busy`, `done`, the accumulator and the counter all go to 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - `busy`=0.
  - If `start`=1: latch `A` into the multiplicand register `M`.
  - Load the accumulator `P` (2*`WIDTH`+1 bits) = {`WIDTH`'b0, `B`, 1'b0}.
  - Load counter = `WIDTH`; go to RUN.
- RUN (`busy`=1), each cycle:
  - Inspect the Booth pair {`P[1]`, `P[0]`}: 01 → upper += `M`; 10 → upper -= `M`; 00/11 → no operation.
  - Then arithmetic-shift `P` right by 1, replicating the sign of the upper part.
  - Decrement the counter. When the counter reaches 1 in this cycle, go to FINISH next cycle.
- Adder width: the upper add/subtract is done at `WIDTH`+1 bits, with `M` sign-extended. This makes `M` = -2^31 (negation overflow) correct.
- FINISH (`busy`=1):
  - `hi` <= `P[2W:W+1]`, `lo` <= `P[W:1]`.
  - `done`=1 for exactly this cycle; go to IDLE.
- Latency:
  - `start` accepted at edge t → `done`=1 and new `hi`/`lo` visible in cycle t+33.
  - Earliest next accept is at edge t+34.
- Hold: `hi`/`lo` keep the last product until the next FINISH. They are never cleared by idling.
- `start` while `busy`=1 is ignored, with no queuing. `A`/`B` changes after acceptance have no effect.
- `start` held high continuously → back-to-back operations, one every 34 cycles.
- `reset` in any state, including mid-RUN, aborts the operation. `done` is not asserted for the aborted operation, and `hi`/`lo` read 0.
- Result is the exact two's-complement 64-bit product. There is no overflow flag and no zero/error flag; all operand values are legal.

Decomposition:
- Package `mult_pkg`:
  - state enum (IDLE, RUN, FINISH);
  - `WIDTH` default 32;
  - localparam `PROD_W` = 2*`WIDTH`;
  - Booth op encodings (NOP, ADD, SUB).
- Optional sub-module `booth_step`: purely combinational. It takes `P` and `M` and returns the next `P` (add/sub plus arithmetic shift). It can be unit-tested independently.
- The FSM, counter and output registers stay in `mult_seq`.

Test Plan:
- `A`=3, `B`=5, `start` 1 cycle → `done` at cycle +33, `hi`=0x00000000, `lo`=0x0000000F, `busy` high cycles +1..+33.
- `A`=-7 (0xFFFFFFF9), `B`=6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6.
- `A`=`B`=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- `A`=`B`=0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001. Also `A`=0x80000000, `B`=-1 → `hi`=0x00000000, `lo`=0x80000000.
- Start 2*3, then pulse `start` with 9*9 at cycle +10 → second start ignored; `done` at +33 with `lo`=6. Then a fresh start → `lo`=0x51.
- Start 4*4, assert `reset` at cycle +15 → `busy`=0, `hi`=`lo`=0, no `done` pulse. A subsequent 2*2 → `lo`=4 after 33 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

   // Default operand width and the matching product width.
   localparam int MULT_WIDTH = 32;
   localparam int PROD_W     = 2 * MULT_WIDTH;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Operation selected by the radix-2 Booth pair {P[1], P[0]}.
   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // 01 ends a run of ones (add M), 10 starts one (subtract M).
   function automatic booth_op_t booth_decode(input logic [1:0] pair);
      case (pair)
         2'b01:   return OP_ADD;
         2'b10:   return OP_SUB;
         default: return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Handshake and result bundle between the control unit and the multiplier.
interface mult_seq_if
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   // Control unit side: issues requests, reads the product.
   modport master (
      output start, A, B,
      input  hi, lo, busy, done
   );

   // Multiplier side.
   modport slave (
      input  start, A, B,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/mult_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the upper
// half of P followed by a one-bit arithmetic right shift. Combinational.
module booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic [2*WIDTH:0]  p_in,
   input  logic [WIDTH-1:0]  m_in,
   output logic [2*WIDTH:0]  p_out
);

   booth_op_t      op;
   logic [WIDTH:0] upper_ext;
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   // Add/sub at WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) cannot
   // wrap; the extra bit becomes the sign that the shift replicates.
   always_comb begin
      op        = booth_decode(p_in[1:0]);
      upper_ext = {p_in[2*WIDTH], p_in[2*WIDTH:WIDTH+1]};
      m_ext     = {m_in[WIDTH-1], m_in};
      case (op)
         OP_ADD:  sum = upper_ext + m_ext;
         OP_SUB:  sum = upper_ext - m_ext;
         default: sum = upper_ext;
      endcase
      // Shift right by one: the WIDTH+1-bit sum drops into the upper part,
      // its top bit supplying the sign of the new accumulator.
      p_out = {sum, p_in[WIDTH:1]};
   end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one iteration
// per clock. Result lands in hi/lo with a one-cycle done pulse.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       reset,
   mult_seq_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [2*WIDTH:0]   p_q, p_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH:0]   p_step;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .p_in  (p_q),
      .m_in  (m_q),
      .p_out (p_step)
   );

   // Next-state logic for the controller, datapath and output registers.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               // Operands are captured here; later A/B changes are ignored.
               m_d     = bus.A;
               p_d     = {{WIDTH{1'b0}}, bus.B, 1'b0};
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            p_d   = p_step;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            // Bit 0 of P is the Booth guard bit, not part of the product.
            hi_d    = p_q[2*WIDTH:WIDTH+1];
            lo_d    = p_q[WIDTH:1];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: table of products plus handshake corner cases.
module tb_mult_seq;

   localparam int W   = 32;
   localparam int LAT = 33;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mult_seq_if #(.WIDTH(W)) bus ();

   mult_seq #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs [11];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one multiply, scramble A/B after acceptance, then watch for done.
   // lat = negedges after the accept edge until done is seen (-1 on timeout).
   // poke_k >= 0 pulses a competing start (9*9) at that point while busy.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_k, output int lat, output int nbusy);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = a ^ 32'h5A5A_A5A5;
      lat   = -1;
      nbusy = 0;
      for (int k = 0; k < 60; k++) begin
         if (bus.done) begin
            lat = k;
            break;
         end
         if (bus.busy) nbusy++;
         if (poke_k >= 0 && k == poke_k) begin
            bus.start = 1'b1;
            bus.A     = 32'd9;
            bus.B     = 32'd9;
         end else if (poke_k >= 0 && k == poke_k + 1) begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      $display("op 0x%08h * 0x%08h -> hi=0x%08h lo=0x%08h latency=%0d busy=%0d",
               a, b, bus.hi, bus.lo, lat, nbusy);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nbusy, ndone, d1, d2;

      vecs[0]  = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
      vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
      vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[3]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
      vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
      vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vecs[7]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
      vecs[8]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
      vecs[9]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
      vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(negedge clk);
      chk("reset hi",   64'(bus.hi),   64'h0);
      chk("reset lo",   64'(bus.lo),   64'h0);
      chk("reset busy", 64'(bus.busy), 64'h0);
      chk("reset done", 64'(bus.done), 64'h0);
      reset = 1'b0;

      // Product table, with latency, busy window, pulse width and hold.
      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, -1, lat, nbusy);
         chk($sformatf("v%0d latency", i), 64'(lat), 64'(LAT));
         chk($sformatf("v%0d busy cycles", i), 64'(nbusy), 64'(LAT));
         chk($sformatf("v%0d product", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
         @(negedge clk);
         chk($sformatf("v%0d done width", i), 64'(bus.done), 64'h0);
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d hold", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
         chk($sformatf("v%0d idle busy", i), 64'(bus.busy), 64'h0);
      end

      // A start pulsed while busy must be dropped, not queued.
      run_op(32'd2, 32'd3, 10, lat, nbusy);
      chk("ignored-start latency", 64'(lat), 64'(LAT));
      chk("ignored-start product", {bus.hi, bus.lo}, 64'd6);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("ignored-start no extra done", 64'(ndone), 64'h0);
      run_op(32'd9, 32'd9, -1, lat, nbusy);
      chk("fresh 9*9 product", {bus.hi, bus.lo}, 64'h51);

      // Reset mid-RUN: no done, outputs cleared, next op works normally.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd4;
      bus.B     = 32'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      chk("pre-reset busy", 64'(bus.busy), 64'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      $display("reset asserted mid-run: busy=%0d hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);
      chk("abort busy", 64'(bus.busy), 64'h0);
      chk("abort hi/lo", {bus.hi, bus.lo}, 64'h0);
      chk("abort done", 64'(bus.done), 64'h0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("abort no done", 64'(ndone), 64'h0);
      run_op(32'd2, 32'd2, -1, lat, nbusy);
      chk("post-abort latency", 64'(lat), 64'(LAT));
      chk("post-abort product", {bus.hi, bus.lo}, 64'd4);

      // start held high: back-to-back operations every 34 cycles.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd2;
      bus.B     = 32'd7;
      d1 = -1;
      d2 = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
      end
      bus.start = 1'b0;
      $display("back-to-back: done at %0d and %0d, lo=0x%08h", d1, d2, bus.lo);
      chk("back-to-back first done seen", 64'(d1 >= 0), 64'h1);
      chk("back-to-back spacing", 64'(d2 - d1), 64'd34);
      chk("back-to-back product", {bus.hi, bus.lo}, 64'd14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
